inv_response_checker: RTL and testbench

- Synthesizable response-side checker for inverter-type DUTs. It is the receiving end of the stimulus/response inversion test.
- Observes the stimulus driven into the DUT (stim) and the DUT output (resp).
- Waits a programmable settle time after every stimulus change, then checks resp == ~stim.
- Keeps pass/fail counts and captures the first failure. Sits beside the DUT in FPGA self-test builds so inversion checks run in hardware without a simulator.

---
 rtl/inv_response_checker.sv | 148 ++++++++++++++
 tb/tb_inv_response_checker.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_response_checker.sv
// Settle-then-compare checker for inverter DUTs: resp must equal ~stim.
// Ports: clk, rst, en, clear in; stim/resp observed;
//   busy, check_pulse, check_pass, pass_cnt, fail_cnt,
//   err_sticky, first_fail_stim, first_fail_resp out.
module inv_response_checker #(
   parameter int WIDTH         = 1,
   parameter int SETTLE_CYCLES = 4,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clear,
   input  logic [WIDTH-1:0] stim,
   input  logic [WIDTH-1:0] resp,
   output logic             busy,
   output logic             check_pulse,
   output logic             check_pass,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic             err_sticky,
   output logic [WIDTH-1:0] first_fail_stim,
   output logic [WIDTH-1:0] first_fail_resp
);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      HOLD
   } state_t;

   localparam logic [7:0]       LAST    = 8'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] stim_q;
   logic [7:0]       cnt;
   logic             changed;
   logic             load;
   logic             cnt_inc;
   logic             do_cmp;
   logic             cmp_ok;

   assign changed = (stim != stim_q);
   assign cmp_ok  = (resp == ~stim_q);

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next state
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (en) state_nxt = SETTLE;
         end
         SETTLE: begin
            if (!en)              state_nxt = IDLE;
            else if (changed)     state_nxt = SETTLE;
            else if (cnt == LAST) state_nxt = HOLD;
         end
         HOLD: begin
            if (!en)          state_nxt = IDLE;
            else if (changed) state_nxt = SETTLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // outputs and datapath controls
   always_comb begin
      busy    = 1'b0;
      load    = 1'b0;
      cnt_inc = 1'b0;
      do_cmp  = 1'b0;
      unique case (state)
         IDLE: begin
            load = en;
         end
         SETTLE: begin
            busy    = 1'b1;
            load    = en && changed;
            cnt_inc = en && !changed && (cnt != LAST);
            do_cmp  = en && !changed && (cnt == LAST);
         end
         HOLD: begin
            load = en && changed;
         end
         default: ;
      endcase
   end

   // stimulus tracking and settle counter
   always_ff @(posedge clk) begin
      if (rst) begin
         stim_q <= '0;
         cnt    <= '0;
      end else if (load) begin
         stim_q <= stim;
         cnt    <= '0;
      end else if (cnt_inc) begin
         cnt <= cnt + 8'd1;
      end
   end

   // compare results; clear discards a coincident compare
   always_ff @(posedge clk) begin
      if (rst) begin
         check_pulse     <= 1'b0;
         check_pass      <= 1'b0;
         pass_cnt        <= '0;
         fail_cnt        <= '0;
         err_sticky      <= 1'b0;
         first_fail_stim <= '0;
         first_fail_resp <= '0;
      end else begin
         check_pulse <= do_cmp && !clear;
         if (clear) begin
            check_pass      <= 1'b0;
            pass_cnt        <= '0;
            fail_cnt        <= '0;
            err_sticky      <= 1'b0;
            first_fail_stim <= '0;
            first_fail_resp <= '0;
         end else if (do_cmp) begin
            check_pass <= cmp_ok;
            if (cmp_ok) begin
               if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + 1'b1;
            end else begin
               if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + 1'b1;
               if (!err_sticky) begin
                  err_sticky      <= 1'b1;
                  first_fail_stim <= stim_q;
                  first_fail_resp <= resp;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_inv_response_checker.sv
// Bench for inv_response_checker: directed segment table, corner
// sequences and random traffic against a history-based reference model.
module tb_inv_response_checker;

   localparam int S    = 4;
   localparam int MAXE = 8192;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en = 1'b0;
   logic clear = 1'b0;
   logic stim = 1'b0;
   logic resp = 1'b0;
   logic inv_q = 1'b0;
   int   mode = 0;

   logic        busy, pulse, pass, err, ffs, ffr;
   logic [15:0] pcnt, fcnt;
   logic        s_busy, s_pulse, s_pass, s_err, s_ffs, s_ffr;
   logic [1:0]  s_pcnt, s_fcnt;

   always #5 clk = ~clk;

   inv_response_checker #(.WIDTH(1), .SETTLE_CYCLES(S), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .en(en), .clear(clear),
      .stim(stim), .resp(resp),
      .busy(busy), .check_pulse(pulse), .check_pass(pass),
      .pass_cnt(pcnt), .fail_cnt(fcnt), .err_sticky(err),
      .first_fail_stim(ffs), .first_fail_resp(ffr)
   );

   inv_response_checker #(.WIDTH(1), .SETTLE_CYCLES(S), .CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .en(en), .clear(clear),
      .stim(stim), .resp(resp),
      .busy(s_busy), .check_pulse(s_pulse), .check_pass(s_pass),
      .pass_cnt(s_pcnt), .fail_cnt(s_fcnt), .err_sticky(s_err),
      .first_fail_stim(s_ffs), .first_fail_resp(s_ffr)
   );

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      else
         n_pass++;
   endtask

   // reference model: per-edge input history
   bit   h_rst [MAXE];
   bit   h_en  [MAXE];
   logic h_stim[MAXE];
   logic h_resp[MAXE];
   int   ne = 0;

   int   p_raw = 0, f_raw = 0;
   logic e_pulse = 0, e_pass = 0, e_err = 0, e_busy = 0;
   logic e_ffs = 0, e_ffr = 0;

   // a stimulus value is adopted at an enabled edge whose predecessor
   // was idle, in reset, or carried a different value
   function automatic bit is_arm(input int k);
      if (k == 0) return 1'b1;
      return h_rst[k-1] || !h_en[k-1] || (h_stim[k-1] !== h_stim[k]);
   endfunction

   // edges since the current value was adopted, -1 if none pending
   function automatic int settle_age(input int t);
      int k;
      for (int a = 0; a <= S; a++) begin
         k = t - a;
         if (k < 0) return -1;
         if (h_rst[k] || !h_en[k]) return -1;
         if (is_arm(k)) return a;
      end
      return -1;
   endfunction

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic model_edge();
      int  t, age;
      bit  cmp, ok;
      if (ne >= MAXE) begin
         $display("FAIL model_history overflow");
         $fatal(1);
      end
      t = ne;
      h_rst[t] = rst;
      h_en[t] = en;
      h_stim[t] = stim;
      h_resp[t] = resp;
      ne++;
      age = settle_age(t);
      cmp = (age == S);
      e_busy = (age >= 0) && (age < S);
      if (rst) begin
         e_pulse = 0; e_pass = 0; e_err = 0; e_ffs = 0; e_ffr = 0;
         p_raw = 0; f_raw = 0;
      end else begin
         e_pulse = cmp && !clear;
         if (clear) begin
            e_pass = 0; e_err = 0; e_ffs = 0; e_ffr = 0;
            p_raw = 0; f_raw = 0;
         end else if (cmp) begin
            ok = (h_resp[t] === ~h_stim[t-S]);
            e_pass = ok;
            if (ok) p_raw++;
            else begin
               f_raw++;
               if (!e_err) begin
                  e_err = 1;
                  e_ffs = h_stim[t-S];
                  e_ffr = h_resp[t];
               end
            end
         end
      end
   endtask

   task automatic check_all();
      chk("busy", busy, e_busy);
      chk("check_pulse", pulse, e_pulse);
      chk("check_pass", pass, e_pass);
      chk("pass_cnt", pcnt, sat(p_raw, 65535));
      chk("fail_cnt", fcnt, sat(f_raw, 65535));
      chk("err_sticky", err, e_err);
      chk("first_fail_stim", ffs, e_ffs);
      chk("first_fail_resp", ffr, e_ffr);
      chk("sat_pass_cnt", s_pcnt, sat(p_raw, 3));
      chk("sat_fail_cnt", s_fcnt, sat(f_raw, 3));
      chk("sat_pulse", s_pulse, e_pulse);
   endtask

   // mode 0: inverter with one-cycle delay, 1: stuck-at-1, 2: random
   task automatic tick();
      case (mode)
         0:       resp = inv_q;
         1:       resp = 1'b1;
         default: resp = 1'($urandom_range(0, 1));
      endcase
      @(posedge clk);
      model_edge();
      #1;
      inv_q = ~stim;
      check_all();
   endtask

   typedef struct {
      logic stim;
      int   mode;
      int   hold;
      int   clr_idx;
      int   e_np;
      int   e_first;
      int   e_p;
      int   e_f;
      logic e_err;
      logic e_ffs;
      logic e_ffr;
   } seg_t;

   seg_t tbl[11];

   task automatic run_seg(input seg_t s, input int idx);
      int np, first;
      np = 0;
      first = -1;
      stim = s.stim;
      mode = s.mode;
      en = 1'b1;
      for (int i = 0; i < s.hold; i++) begin
         clear = (i == s.clr_idx);
         tick();
         if (pulse === 1'b1) begin
            if (first < 0) first = i;
            np++;
         end
      end
      clear = 1'b0;
      chk($sformatf("seg%0d_pulses", idx), np, s.e_np);
      chk($sformatf("seg%0d_first", idx), first, s.e_first);
      chk($sformatf("seg%0d_pass_cnt", idx), pcnt, s.e_p);
      chk($sformatf("seg%0d_fail_cnt", idx), fcnt, s.e_f);
      chk($sformatf("seg%0d_err", idx), err, s.e_err);
      chk($sformatf("seg%0d_ff_stim", idx), ffs, s.e_ffs);
      chk($sformatf("seg%0d_ff_resp", idx), ffr, s.e_ffr);
   endtask

   initial begin
      int np, first;

      // stim, mode, hold, clr_idx, pulses, first, pass, fail, err, ffs, ffr
      tbl[0]  = '{1'b1, 0, 10, -1, 1, 4, 1, 0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 0, 10, -1, 1, 4, 2, 0, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 0, 10, -1, 1, 4, 3, 0, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 0, 10, -1, 1, 4, 4, 0, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 1, 10,  0, 1, 4, 0, 1, 1'b1, 1'b1, 1'b1};
      tbl[5]  = '{1'b0, 1, 10, -1, 1, 4, 1, 1, 1'b1, 1'b1, 1'b1};
      tbl[6]  = '{1'b1, 1, 10, -1, 1, 4, 1, 2, 1'b1, 1'b1, 1'b1};
      tbl[7]  = '{1'b0, 0,  2,  0, 0, -1, 0, 0, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{1'b1, 0, 10, -1, 1, 4, 1, 0, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{1'b0, 0, 10,  4, 0, -1, 0, 0, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 0, 10, -1, 1, 4, 1, 0, 1'b0, 1'b0, 1'b0};

      // reset
      rst = 1'b1;
      en = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      chk("rst_pass_cnt", pcnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pulse", pulse, 0);
      rst = 1'b0;

      for (int i = 0; i < 11; i++) run_seg(tbl[i], i);

      // reset two cycles into a settle window
      mode = 0;
      stim = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_busy", busy, 0);
      chk("midrst_pulse", pulse, 0);
      chk("midrst_pass", pass, 0);
      chk("midrst_pass_cnt", pcnt, 0);
      chk("midrst_fail_cnt", fcnt, 0);
      chk("midrst_err", err, 0);
      mode = 1;
      stim = 1'b0;
      en = 1'b1;
      np = 0;
      first = -1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (pulse === 1'b1) begin
            if (first < 0) first = i;
            np++;
         end
      end
      chk("postrst_pulses", np, 1);
      chk("postrst_first", first, 4);
      chk("postrst_pass_cnt", pcnt, 1);

      // en dropped inside a settle window
      mode = 0;
      stim = 1'b1;
      np = 0;
      tick();
      if (pulse === 1'b1) np++;
      tick();
      if (pulse === 1'b1) np++;
      en = 1'b0;
      tick();
      if (pulse === 1'b1) np++;
      chk("endrop_busy", busy, 0);
      en = 1'b1;
      first = -1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (pulse === 1'b1) begin
            if (first < 0) first = i;
            np++;
         end
      end
      chk("endrop_pulses", np, 1);
      chk("endrop_first", first, 4);
      chk("endrop_pass_cnt", pcnt, 2);

      // saturation of the narrow-counter instance
      clear = 1'b1;
      tick();
      clear = 1'b0;
      for (int j = 0; j < 5; j++) begin
         stim = ~stim;
         for (int i = 0; i < 6; i++) tick();
      end
      chk("satur_main_pass_cnt", pcnt, 5);
      chk("satur_narrow_pass_cnt", s_pcnt, 3);
      chk("satur_narrow_fail_cnt", s_fcnt, 0);

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 199) == 0);
         clear = ($urandom_range(0, 59) == 0);
         en = ($urandom_range(0, 24) != 0);
         if ($urandom_range(0, 6) == 0) stim = ~stim;
         if ($urandom_range(0, 39) == 0) mode = int'($urandom_range(0, 2));
         tick();
      end
      rst = 1'b0;
      clear = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
